// File: rtl/systolic_pkg.sv
// Types, defaults and lane helpers shared by the systolic array output path.
package systolic_pkg;

  localparam int ARRAY_COLS = 32;
  localparam int PSUM_W     = 32;
  localparam int PSUM_IW    = $clog2(PSUM_W);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} drain_state_t;

  // msb_idx picks the sign bit so lanes narrower than PSUM_W can reuse this.
  function automatic logic [PSUM_W-1:0] relu_lane(input logic [PSUM_W-1:0] v,
                                                  input logic [PSUM_IW-1:0] msb_idx);
    return v[msb_idx] ? '0 : v;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Aligned-row FIFO: head entry shown combinationally on dout, write-to-empty-deassert 1 cycle.
// A write when full is taken only together with a read; clr empties it synchronously.
module row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      level_q;
  logic             wr, rd;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign dout  = mem_q[rp_q];
  assign rd    = rd_en && !empty;
  assign wr    = wr_en && (!full || rd);

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else if (clr) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      level_q <= level_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Deskews per-column psums into rows (out_en[0] to row_valid: COLS cycles); full FIFO drops rows (sticky overflow),
// no backpressure to the array. Optional DRAIN_RELU_EN clamps negative lanes to zero on FIFO write.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int COLS  = ARRAY_COLS,
  parameter int DW    = PSUM_W,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 w_ps,
  input  logic                 conv_finish,
  input  logic [COLS-1:0]      out_en,
  input  logic [COLS*DW-1:0]   psum_in,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [COLS*DW-1:0]   row_data,
  output logic                 drain_done,
  output logic                 overflow,
  output logic                 skew_err
);

  localparam int CW = $clog2(COLS) + 1;
  localparam int LW = $clog2(DEPTH) + 1;

  drain_state_t       state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d, skew_q, skew_d;
  logic               capture, abort;
  logic [COLS-1:0]    en_in, en_dly;
  logic [COLS*DW-1:0] dat_dly, wr_dat, fifo_dout;
  logic               aligned, mixed, wr_req, fifo_wr, fifo_rd;
  logic               fifo_full, fifo_empty, going_empty;
  logic [LW-1:0]      fifo_level;

  assign en_in = out_en & {COLS{capture}};

  // Lane c waits COLS-1-c cycles so every lane of a row lines up with the last column.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign en_dly[c]            = en_in[c];
      assign dat_dly[c*DW +: DW]  = psum_in[c*DW +: DW];
    end else begin : g_dly
      logic [D-1:0]  en_q;
      logic [DW-1:0] dat_q [D];
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          en_q <= '0;
          for (int i = 0; i < D; i++) dat_q[i] <= '0;
        end else begin
          en_q[0]  <= en_in[c] && !abort;
          dat_q[0] <= psum_in[c*DW +: DW];
          for (int i = 1; i < D; i++) begin
            en_q[i]  <= en_q[i-1] && !abort;
            dat_q[i] <= dat_q[i-1];
          end
        end
      end
      assign en_dly[c]           = en_q[D-1];
      assign dat_dly[c*DW +: DW] = dat_q[D-1];
    end
  end

  assign aligned = &en_dly;
  assign mixed   = (|en_dly) && !aligned;
  assign wr_req  = aligned && !abort;

`ifdef DRAIN_RELU_EN
  always_comb begin
    wr_dat = '0;
    for (int c = 0; c < COLS; c++)
      wr_dat[c*DW +: DW] = DW'(relu_lane(PSUM_W'(dat_dly[c*DW +: DW]), PSUM_IW'(DW-1)));
  end
`else
  assign wr_dat = dat_dly;
`endif

  assign fifo_rd = !fifo_empty && row_ready;
  assign fifo_wr = wr_req && (!fifo_full || fifo_rd);

  row_fifo #(.WIDTH(COLS*DW), .DEPTH(DEPTH)) u_row_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (abort),
    .wr_en (fifo_wr),
    .din   (wr_dat),
    .full  (fifo_full),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign row_valid = !fifo_empty;
  assign row_data  = fifo_empty ? '0 : fifo_dout;
  // Lets DONE land in the first cycle the FIFO reads empty, right after the last handshake.
  assign going_empty = !fifo_wr && (fifo_empty || (fifo_rd && fifo_level == LW'(1)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!w_ps) state_d = COLLECT;
      COLLECT: if (w_ps) state_d = IDLE;
               else if (conv_finish) state_d = FLUSH;
      FLUSH:   if (w_ps) state_d = IDLE;
               else if (cnt_q == '0 && going_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture    = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      COLLECT, FLUSH: capture    = 1'b1;
      DONE:           drain_done = 1'b1;
      default:        ;
    endcase
  end

  assign abort = capture && w_ps;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == COLLECT && state_d == FLUSH) cnt_d = CW'(COLS - 1);
    else if (state_q == FLUSH && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
    ovf_d  = ovf_q || (wr_req && fifo_full && !fifo_rd);
    skew_d = skew_q || mixed;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      skew_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      skew_q <= skew_d;
    end
  end

  assign overflow = ovf_q;
  assign skew_err = skew_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain (COLS=4, DW=16, DEPTH=4) against a cycle-indexed reference model.
module tb_systolic_drain;

  localparam int COLS = 4, DW = 16, DEPTH = 4, NC = 2048;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_FLUSH = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        nrst, w_ps, conv_finish, row_ready;
  logic        row_valid, drain_done, overflow, skew_err;
  logic [3:0]  out_en;
  logic [63:0] psum_in, row_data;

  always #5 clk = ~clk;

  systolic_drain #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .w_ps        (w_ps),
    .conv_finish (conv_finish),
    .out_en      (out_en),
    .psum_in     (psum_in),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .drain_done  (drain_done),
    .overflow    (overflow),
    .skew_err    (skew_err)
  );

  int n_cmp = 0, n_bad = 0, n = 0;

  // Stimulus schedule and controls
  logic [3:0]  sch_en [NC];
  logic [63:0] sch_d  [NC];
  logic        rst_v, wps_v;
  int          cf_cyc, rdy_mode;

  // Reference model
  logic [3:0]  hist_en [NC];
  logic [63:0] hist_d  [NC];
  logic [63:0] mq[$];
  int          ms, fe, clr_from;
  logic        movf, mskew;

  // Observation
  logic [63:0] hs_q[$];
  logic [63:0] first_dat;
  int          first_vld, last_hs, done_cnt, done_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [63:0] exp_row(input logic [63:0] v);
    logic [63:0] r = v;
`ifdef DRAIN_RELU_EN
    for (int c = 0; c < 4; c++) if (v[c*16+15]) r[c*16 +: 16] = '0;
`endif
    return r;
  endfunction

  task automatic put_lane(input int t, input int c, input logic [15:0] v);
    if (t >= 0 && t < NC) begin
      sch_en[t][c]         = 1'b1;
      sch_d[t][c*16 +: 16] = v;
    end
  endtask

  task automatic put_row(input int t, input logic [63:0] v);
    for (int c = 0; c < 4; c++) put_lane(t + c, c, v[c*16 +: 16]);
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 1'b0; mskew = 1'b0; ms = M_IDLE; fe = 0; clr_from = n + 1;
  endtask

  // Row lane c at cycle n is whatever lane c captured COLS-1-c cycles earlier.
  task automatic model_edge();
    logic        cap, wr, rd, was_full;
    logic [3:0]  ae;
    logic [63:0] ad;
    cap = (ms == M_COLLECT || ms == M_FLUSH);
    hist_en[n] = cap ? out_en : 4'b0;
    hist_d[n]  = psum_in;
    ae = 4'b0; ad = 64'h0;
    for (int c = 0; c < 4; c++) begin
      int idx = n - (3 - c);
      if (idx >= 0 && idx >= clr_from) begin
        ae[c]          = hist_en[idx][c];
        ad[c*16 +: 16] = hist_d[idx][c*16 +: 16];
      end
    end
    if (ae != 4'b0 && ae != 4'hF) mskew = 1'b1;
    wr = (ae == 4'hF);
    rd = (mq.size() > 0) && row_ready;
    if (w_ps && cap) begin
      mq.delete();
      clr_from = n + 1;
      ms = M_IDLE;
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (rd) void'(mq.pop_front());
    if (wr) begin
      if (was_full && !rd) movf = 1'b1;
      else mq.push_back(exp_row(ad));
    end
    case (ms)
      M_IDLE:    if (!w_ps) ms = M_COLLECT;
      M_COLLECT: if (conv_finish) begin ms = M_FLUSH; fe = n + 1; end
      M_FLUSH:   if (n >= fe + 3 && mq.size() == 0) ms = M_DONE;
      default:   ms = M_IDLE;
    endcase
  endtask

  task automatic run(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      nrst        = rst_v;
      w_ps        = wps_v;
      conv_finish = (n == cf_cyc);
      out_en      = sch_en[n];
      psum_in     = sch_d[n];
      case (rdy_mode)
        0:       row_ready = 1'b0;
        1:       row_ready = 1'b1;
        2:       row_ready = ($urandom_range(0, 99) < 65);
        default: row_ready = n[0];
      endcase
      @(negedge clk);
      if (!rst_v) model_reset();
      check_eq("row_valid",  row_valid,  mq.size() > 0);
      check_eq("row_data",   row_data,   (mq.size() > 0) ? mq[0] : 64'h0);
      check_eq("drain_done", drain_done, ms == M_DONE);
      check_eq("overflow",   overflow,   movf);
      check_eq("skew_err",   skew_err,   mskew);
      if (row_valid && first_vld < 0) begin first_vld = n; first_dat = row_data; end
      if (row_valid && row_ready) begin hs_q.push_back(row_data); last_hs = n; end
      if (drain_done) begin done_cnt++; done_cyc = n; end
      if (rst_v) model_edge();
      n++;
    end
  endtask

  initial begin
    int t;
    logic [63:0] rows3 [6];
    logic [63:0] ra, rb, rc, exp6;

    nrst = 1'b0; w_ps = 1'b1; conv_finish = 1'b0; row_ready = 1'b0;
    out_en = '0; psum_in = '0;
    rst_v = 1'b0; wps_v = 1'b1; cf_cyc = -1; rdy_mode = 1;
    first_vld = -1; last_hs = -1; done_cnt = 0; done_cyc = -1; first_dat = '0;
    for (int i = 0; i < NC; i++) begin
      sch_en[i] = '0;
      sch_d[i]  = {$urandom, $urandom};
    end
    model_reset();

    // Reset state
    run(3);
    check_eq("rst_valid", row_valid, 1'b0);
    check_eq("rst_data",  row_data,  64'h0);
    check_eq("rst_done",  drain_done, 1'b0);
    check_eq("rst_ovf",   overflow,  1'b0);
    check_eq("rst_skew",  skew_err,  1'b0);
    rst_v = 1'b1;
    run(2);

    // Latency: w_ps falls, one skewed row
    wps_v = 1'b0;
    run(1);
    t = n + 2;
    put_row(t, 64'h0004_0003_0002_0001);
    first_vld = -1;
    run(10);
    check_eq("lat_first_valid", 64'(first_vld), 64'(t + 4));
    check_eq("lat_row_data", first_dat, 64'h0004_0003_0002_0001);

    // Six back-to-back rows into a stalled FIFO
    rdy_mode = 0;
    t = n + 1;
    for (int r = 0; r < 6; r++) begin
      rows3[r] = {$urandom, $urandom};
      put_row(t + r, rows3[r]);
    end
    run(14);
    check_eq("ovf_set", overflow, 1'b1);
    hs_q.delete();
    rdy_mode = 1;
    run(8);
    check_eq("ovf_delivered", 64'(hs_q.size()), 64'd4);
    for (int r = 0; r < 4 && r < hs_q.size(); r++)
      check_eq("ovf_row_order", hs_q[r], exp_row(rows3[r]));

    // Reset with two rows pending
    rdy_mode = 0;
    t = n + 1;
    for (int r = 0; r < 3; r++) put_row(t + r, {$urandom, $urandom});
    run(t + 5 - n);
    check_eq("mid_rows_pending", row_valid, 1'b1);
    rst_v = 1'b0;
    run(1);
    check_eq("mid_rst_valid", row_valid, 1'b0);
    check_eq("mid_rst_data",  row_data,  64'h0);
    check_eq("mid_rst_ovf",   overflow,  1'b0);
    run(1);
    rst_v = 1'b1; wps_v = 1'b1;
    run(2);
    wps_v = 1'b0;
    run(2);

    // Lane 2 one cycle late
    check_eq("skew_clear", skew_err, 1'b0);
    rdy_mode = 1;
    t = n + 1;
    ra = 64'h1111_2222_3333_4444; rb = 64'h0A0B_0C0D_0E0F_0102; rc = 64'h7000_0100_0020_0003;
    put_row(t, ra);
    put_lane(t + 6, 0, 16'h5555); put_lane(t + 7, 1, 16'h6666);
    put_lane(t + 9, 2, 16'h7777); put_lane(t + 9, 3, 16'h0888);
    put_row(t + 12, rb);
    put_row(t + 13, rc);
    hs_q.delete();
    run(24);
    check_eq("skew_set", skew_err, 1'b1);
    check_eq("skew_rows", 64'(hs_q.size()), 64'd3);
    if (hs_q.size() == 3) begin
      check_eq("skew_row0", hs_q[0], exp_row(ra));
      check_eq("skew_row1", hs_q[1], exp_row(rb));
      check_eq("skew_row2", hs_q[2], exp_row(rc));
    end

    // conv_finish with the final row, row_ready toggling
    t = n + 1;
    put_row(t, {$urandom, $urandom});
    put_row(t + 2, {$urandom, $urandom});
    cf_cyc = t + 2;
    rdy_mode = 3;
    done_cnt = 0;
    hs_q.delete();
    run(25);
    check_eq("done_pulses", 64'(done_cnt), 64'd1);
    check_eq("done_after_hs", 64'(done_cyc), 64'(last_hs + 1));
    check_eq("done_rows", 64'(hs_q.size()), 64'd2);

    // w_ps abort with rows buffered
    rdy_mode = 0;
    t = n + 1;
    put_row(t, {$urandom, $urandom});
    put_row(t + 1, {$urandom, $urandom});
    run(t + 5 - n);
    wps_v = 1'b1;
    run(2);
    check_eq("abort_empty", row_valid, 1'b0);
    check_eq("abort_no_done", 64'(done_cnt), 64'd1);
    wps_v = 1'b0;
    run(3);

    // Signed lanes {-5,7,-1,0}
`ifdef DRAIN_RELU_EN
    exp6 = 64'h0000_0000_0007_0000;
`else
    exp6 = 64'h0000_FFFF_0007_FFFB;
`endif
    rdy_mode = 1;
    t = n + 1;
    put_row(t, 64'h0000_FFFF_0007_FFFB);
    hs_q.delete();
    run(10);
    check_eq("relu_rows", 64'(hs_q.size()), 64'd1);
    if (hs_q.size() == 1) check_eq("relu_lanes", hs_q[0], exp6);

    // Random rows, random ready, then drain
    rdy_mode = 2;
    done_cnt = 0;
    t = n + 1;
    for (int k = 0; k < 60; k++) begin
      put_row(t, {$urandom, $urandom});
      cf_cyc = t;
      t += $urandom_range(1, 3);
    end
    run(t - n + 60);
    check_eq("rand_done", 64'(done_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
